// File: rtl/slot_alloc_pkg.sv
// ---------------------------------------------------------------------------
// slot_alloc_pkg
//   Shared types and helpers for the slot allocator.
//   - ID_W / CNT_W, id_t / cnt_t : widths and types for the default pool size.
//   - next_ptr_w(id, w)          : rotating-pointer advance with wrap at w-1.
//   - next_ptr(id)               : the same wrap for the default pool size.
//   Modules re-derive their widths from their own W parameter; only the
//   width-independent helper is used there.
// ---------------------------------------------------------------------------
package slot_alloc_pkg;

   localparam int unsigned W_DEFAULT = 32;
   localparam int unsigned ID_W      = $clog2(W_DEFAULT);
   localparam int unsigned CNT_W     = $clog2(W_DEFAULT + 1);

   typedef logic [ID_W-1:0]  id_t;
   typedef logic [CNT_W-1:0] cnt_t;

   // The search resumes one past the last grant, wrapping from w-1 back to 0.
   // The wrap is an explicit compare so that w need not be a power of two.
   function automatic int unsigned next_ptr_w(input int unsigned id, input int unsigned w);
      return (id >= w - 1) ? 0 : id + 1;
   endfunction

   function automatic id_t next_ptr(input id_t id);
      return id_t'(next_ptr_w(32'(id), W_DEFAULT));
   endfunction

endpackage

// File: rtl/slot_alloc_scan.sv
// ---------------------------------------------------------------------------
// slot_alloc_scan
//   Purely combinational circular first-zero search.
//   Ports:
//     vec_i    [W-1:0]     occupancy vector (1 = busy)
//     start_i  [ID_W-1:0]  index where the search begins (must be < W)
//     onehot_o [W-1:0]     one-hot of the first free index found
//     id_o     [ID_W-1:0]  encoded index of the first free slot
//     any_o                at least one slot is free
//   Search order: start, start+1, ..., W-1, 0, ..., start-1.
// ---------------------------------------------------------------------------
module slot_alloc_scan
   import slot_alloc_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0]          vec_i,
   input  logic [$clog2(W)-1:0]  start_i,
   output logic [W-1:0]          onehot_o,
   output logic [$clog2(W)-1:0]  id_o,
   output logic                  any_o
);

   localparam int unsigned ID_W = $clog2(W);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;

   // NOTE: every variable written here gets a default before the loop, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      onehot_o = '0;
      id_o     = '0;
      any_o    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int i = 0; i < int'(W); i++) begin
         // One extra bit holds start+i before the modulo-W fold-back, which
         // keeps non-power-of-two pool sizes correct.
         sum = {1'b0, start_i} + (ID_W+1)'(i);
         if (sum >= (ID_W+1)'(W)) begin
            sum = sum - (ID_W+1)'(W);
         end
         idx = sum[ID_W-1:0];
         if (!any_o && !vec_i[idx]) begin
            any_o         = 1'b1;
            id_o          = idx;
            onehot_o[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/slot_alloc.sv
// ---------------------------------------------------------------------------
// slot_alloc
//   Slot allocator/reclaimer for a W-entry pool. Holds a registered busy
//   vector, a rotating search pointer and an occupancy count; grants the next
//   free slot in circular order starting at the pointer, and takes back
//   released slots.
//   Ports:
//     clk, arst_n            clock, asynchronous active-low reset
//     alloc_vld_o            a free slot is available
//     alloc_id_o             slot granted if alloc_i is high this cycle
//     alloc_i                consumer takes alloc_id_o this cycle
//     free_vld_i, free_id_i  release request and the slot being released
//     busy_o                 registered occupancy vector (1 = allocated)
//     cnt_o                  number of allocated slots
//     full_o, empty_o        cnt_o == W, cnt_o == 0
//     err_o                  sticky protocol-error flag
//   Build option: define SLOT_ALLOC_CHECK_EN to enable err_o and the
//   protocol/consistency assertions; otherwise err_o is tied low.
// ---------------------------------------------------------------------------
module slot_alloc
   import slot_alloc_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic                    clk,
   input  logic                    arst_n,
   output logic                    alloc_vld_o,
   output logic [$clog2(W)-1:0]    alloc_id_o,
   input  logic                    alloc_i,
   input  logic                    free_vld_i,
   input  logic [$clog2(W)-1:0]    free_id_i,
   output logic [W-1:0]            busy_o,
   output logic [$clog2(W+1)-1:0]  cnt_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic                    err_o
);

   localparam int unsigned ID_W  = $clog2(W);
   localparam int unsigned CNT_W = $clog2(W + 1);

   if (W < 2) begin : g_bad_w
      $error("slot_alloc: W must be at least 2");
   end

   logic [W-1:0]     busy_q, busy_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [W-1:0]     scan_onehot;
   logic [ID_W-1:0]  scan_id;
   logic             scan_any;
   logic             free_in_range;
   logic             free_busy;
   logic             alloc_fire;
   logic             free_fire;

   slot_alloc_scan #(.W(W)) u_scan (
      .vec_i    (busy_q),
      .start_i  (ptr_q),
      .onehot_o (scan_onehot),
      .id_o     (scan_id),
      .any_o    (scan_any)
   );

   // With a power-of-two pool every encodable ID is a real slot.
   if ((1 << ID_W) == W) begin : g_range_full
      assign free_in_range = 1'b1;
   end else begin : g_range_cmp
      assign free_in_range = (32'(free_id_i) < W);
   end

   // cnt tracks popcount(busy), so "some bit is zero" and "not full" agree.
   assign alloc_vld_o = scan_any;
   assign alloc_id_o  = scan_id;
   assign alloc_fire  = alloc_i & alloc_vld_o;

   // The granted slot is by construction not busy, so a same-cycle free of
   // that ID fails the busy test and is ignored without extra logic.
   assign free_busy = free_in_range & busy_q[free_id_i];
   assign free_fire = free_vld_i & free_busy;

   always_comb begin
      busy_d = busy_q;
      ptr_d  = ptr_q;
      if (alloc_fire) begin
         busy_d = busy_d | scan_onehot;
         ptr_d  = ID_W'(next_ptr_w(32'(scan_id), W));
      end
      if (free_fire) begin
         busy_d[free_id_i] = 1'b0;
      end
      cnt_d = cnt_q + CNT_W'(alloc_fire) - CNT_W'(free_fire);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others; all state, including the busy vector,
   // is cleared by reset because consumers rely on a known-empty pool.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         busy_q <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o  = busy_q;
   assign cnt_o   = cnt_q;
   assign full_o  = (cnt_q == CNT_W'(W));
   assign empty_o = (cnt_q == '0);

`ifdef SLOT_ALLOC_CHECK_EN
   logic err_q, err_d;
   logic bad_free, bad_alloc;

   assign bad_free  = free_vld_i & ~free_busy;
   assign bad_alloc = alloc_i & ~alloc_vld_o;

   always_comb begin
      err_d = err_q | bad_free | bad_alloc;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

   a_free_legal : assert property (@(posedge clk) disable iff (!arst_n) !bad_free)
      else $warning("slot_alloc: free of a non-busy or out-of-range slot");
   a_alloc_legal : assert property (@(posedge clk) disable iff (!arst_n) !bad_alloc)
      else $warning("slot_alloc: alloc while no slot is free");
   a_cnt_consistent : assert property (@(posedge clk) disable iff (!arst_n)
      $countones(busy_q) == int'(32'(cnt_q)))
      else $error("slot_alloc: cnt disagrees with busy popcount");
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_slot_alloc.sv
// ---------------------------------------------------------------------------
// tb_slot_alloc
//   Self-checking bench for slot_alloc (W = 32). A small behavioural model
//   of the pool predicts every grant; expected grant IDs go into a scoreboard
//   queue when alloc_i is driven and are compared against alloc_id_o. A
//   constant table covers the first grants from reset, and hand-written
//   sequences cover fill/refill, pointer wrap, simultaneous alloc/free,
//   illegal frees and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_slot_alloc;

   localparam int W = 32;
`ifdef SLOT_ALLOC_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         arst_n = 1'b0;
   logic         alloc_vld_o;
   logic [4:0]   alloc_id_o;
   logic         alloc_i = 1'b0;
   logic         free_vld_i = 1'b0;
   logic [4:0]   free_id_i = '0;
   logic [W-1:0] busy_o;
   logic [5:0]   cnt_o;
   logic         full_o;
   logic         empty_o;
   logic         err_o;

   slot_alloc #(.W(W)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .alloc_vld_o (alloc_vld_o),
      .alloc_id_o  (alloc_id_o),
      .alloc_i     (alloc_i),
      .free_vld_i  (free_vld_i),
      .free_id_i   (free_id_i),
      .busy_o      (busy_o),
      .cnt_o       (cnt_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model of the pool.
   logic [W-1:0] m_busy;
   int           m_ptr;
   int           m_cnt;
   bit           m_err;
   int           sb_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_scan();
      for (int k = 0; k < W; k++) begin
         if (!m_busy[(m_ptr + k) % W]) return (m_ptr + k) % W;
      end
      return 0;
   endfunction

   task automatic model_step(input bit a, input bit fv, input int fid);
      int g;
      bit af, ff;
      g  = m_scan();
      af = a && (m_cnt < W);
      ff = fv && m_busy[fid];
      if (CHK && ((fv && !m_busy[fid]) || (a && m_cnt == W))) m_err = 1'b1;
      if (af) begin
         m_busy[g] = 1'b1;
         m_ptr     = (g + 1) % W;
      end
      if (ff) m_busy[fid] = 1'b0;
      m_cnt = m_cnt + int'(af) - int'(ff);
   endtask

   // One clock: drive inputs just after an edge, check the grant before the
   // next edge, then check registered state just after it.
   task automatic cycle(input bit a, input bit fv, input int fid);
      int exp_id;
      alloc_i    = a;
      free_vld_i = fv;
      free_id_i  = 5'(fid);
      #1;
      if (a && m_cnt < W) sb_q.push_back(m_scan());
      if (sb_q.size() > 0) begin
         exp_id = sb_q.pop_front();
         check("grant_vld", 64'(alloc_vld_o), 64'(1));
         check("grant_id", 64'(alloc_id_o), 64'(exp_id));
      end
      model_step(a, fv, fid);
      @(posedge clk);
      #1;
      alloc_i    = 1'b0;
      free_vld_i = 1'b0;
      check("busy", 64'(busy_o), 64'(m_busy));
      check("cnt", 64'(cnt_o), 64'(m_cnt));
      check("full", 64'(full_o), 64'(m_cnt == W));
      check("empty", 64'(empty_o), 64'(m_cnt == 0));
      check("vld", 64'(alloc_vld_o), 64'(m_cnt < W));
      check("err", 64'(err_o), 64'(m_err));
      if (m_cnt < W) check("next_id", 64'(alloc_id_o), 64'(m_scan()));
   endtask

   // Asserts reset between edges and checks that state clears without a clock.
   task automatic do_reset();
      #2;
      arst_n = 1'b0;
      #1;
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_cnt", 64'(cnt_o), 64'(0));
      check("rst_empty", 64'(empty_o), 64'(1));
      check("rst_full", 64'(full_o), 64'(0));
      check("rst_vld", 64'(alloc_vld_o), 64'(1));
      check("rst_id", 64'(alloc_id_o), 64'(0));
      check("rst_err", 64'(err_o), 64'(0));
      m_busy = '0;
      m_ptr  = 0;
      m_cnt  = 0;
      m_err  = 1'b0;
      sb_q.delete();
      @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   typedef struct {
      bit           a;
      bit           fv;
      int           fid;
      int           exp_id;    // alloc_id_o before the edge
      logic [W-1:0] exp_busy;  // busy_o after the edge
      int           exp_cnt;   // cnt_o after the edge
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{a: 1'b1, fv: 1'b0, fid: 0, exp_id: 0, exp_busy: 32'h0000_0001, exp_cnt: 1};
      tbl[1] = '{a: 1'b1, fv: 1'b0, fid: 0, exp_id: 1, exp_busy: 32'h0000_0003, exp_cnt: 2};
      tbl[2] = '{a: 1'b1, fv: 1'b0, fid: 0, exp_id: 2, exp_busy: 32'h0000_0007, exp_cnt: 3};
      tbl[3] = '{a: 1'b1, fv: 1'b0, fid: 0, exp_id: 3, exp_busy: 32'h0000_000F, exp_cnt: 4};
      tbl[4] = '{a: 1'b0, fv: 1'b0, fid: 0, exp_id: 4, exp_busy: 32'h0000_000F, exp_cnt: 4};

      // Reset, then the first grants from the constant table.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         alloc_i    = tbl[i].a;
         free_vld_i = tbl[i].fv;
         free_id_i  = 5'(tbl[i].fid);
         #1;
         check("tbl_id", 64'(alloc_id_o), 64'(tbl[i].exp_id));
         cycle(tbl[i].a, tbl[i].fv, tbl[i].fid);
         check("tbl_busy", 64'(busy_o), 64'(tbl[i].exp_busy));
         check("tbl_cnt", 64'(cnt_o), 64'(tbl[i].exp_cnt));
      end

      // Fill the pool, release slot 5, take it back.
      repeat (28) cycle(1'b1, 1'b0, 0);
      check("fill_full", 64'(full_o), 64'(1));
      check("fill_vld", 64'(alloc_vld_o), 64'(0));
      cycle(1'b0, 1'b1, 5);
      check("refill_vld", 64'(alloc_vld_o), 64'(1));
      check("refill_id", 64'(alloc_id_o), 64'(5));
      cycle(1'b1, 1'b0, 0);
      check("refill_full", 64'(full_o), 64'(1));

      // Build busy = {0, 30, 31} with ptr = 30, then scan wraps to slot 1.
      do_reset();
      repeat (32) cycle(1'b1, 1'b0, 0);
      cycle(1'b0, 1'b1, 29);
      cycle(1'b1, 1'b0, 0);
      for (int id = 1; id <= 29; id++) cycle(1'b0, 1'b1, id);
      check("wrap_busy", 64'(busy_o), 64'(32'hC000_0001));
      check("wrap_id", 64'(alloc_id_o), 64'(1));
      cycle(1'b1, 1'b0, 0);
      cycle(1'b0, 1'b1, 1);
      // Slot 1 is free again, but the pointer now sits at 2.
      check("wrap_ptr", 64'(alloc_id_o), 64'(2));

      // Simultaneous alloc and free with cnt = 10.
      do_reset();
      repeat (32) cycle(1'b1, 1'b0, 0);
      cycle(1'b0, 1'b1, 7);
      for (int id = 11; id < W; id++) cycle(1'b0, 1'b1, id);
      check("pair_cnt_pre", 64'(cnt_o), 64'(10));
      check("pair_id", 64'(alloc_id_o), 64'(7));
      cycle(1'b1, 1'b1, 2);
      check("pair_cnt", 64'(cnt_o), 64'(10));
      check("pair_b7", 64'(busy_o[7]), 64'(1));
      check("pair_b2", 64'(busy_o[2]), 64'(0));
      // Free of the very slot being granted is ignored.
      check("same_id", 64'(alloc_id_o), 64'(11));
      cycle(1'b1, 1'b1, 11);
      check("same_b11", 64'(busy_o[11]), 64'(1));
      check("same_cnt", 64'(cnt_o), 64'(11));

      // Illegal free of slot 9 and alloc while full.
      do_reset();
      cycle(1'b0, 1'b1, 9);
      check("badfree_err", 64'(err_o), 64'(CHK));
      check("badfree_busy", 64'(busy_o), 64'(0));
      repeat (3) cycle(1'b0, 1'b0, 0);
      check("err_sticky", 64'(err_o), 64'(CHK));
      repeat (32) cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b0, 0);
      check("full_alloc_cnt", 64'(cnt_o), 64'(32));

      // Random traffic against the model, then reset mid-operation.
      do_reset();
      repeat (300) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, W - 1)));
      do_reset();
      cycle(1'b1, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
